// File: rtl/alu_dot_sequencer_if.sv
// alu_dot_sequencer_if: scheduler, operand-memory and ALU buses of the dot-product sequencer
interface alu_dot_sequencer_if #(parameter int DW = 16, parameter int AW = 8);
  logic          start_i;
  logic [AW-1:0] len_i;
  logic [AW-1:0] a_base_i;
  logic [AW-1:0] b_base_i;
  logic [AW-1:0] b_stride_i;
  logic [AW-1:0] a_addr_o;
  logic [AW-1:0] b_addr_o;
  logic          mem_rd_o;
  logic [DW-1:0] a_data_i;
  logic [DW-1:0] b_data_i;
  logic [1:0]    alu_opcode_o;
  logic [DW-1:0] alu_a_o;
  logic [DW-1:0] alu_b_o;
  logic [DW-1:0] alu_c_i;
  logic          busy_o;
  logic          done_o;
  logic [DW-1:0] result_o;
  modport master (
    output start_i, len_i, a_base_i, b_base_i, b_stride_i, a_data_i, b_data_i, alu_c_i,
    input  a_addr_o, b_addr_o, mem_rd_o, alu_opcode_o, alu_a_o, alu_b_o, busy_o, done_o, result_o
  );
  modport slave (
    input  start_i, len_i, a_base_i, b_base_i, b_stride_i, a_data_i, b_data_i, alu_c_i,
    output a_addr_o, b_addr_o, mem_rd_o, alu_opcode_o, alu_a_o, alu_b_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/alu_dot_sequencer.sv
// alu_dot_sequencer: drives a shared ALU through MUL/ADD per term to form sum(A[k]*B[k*stride])
module alu_dot_sequencer #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input logic              clk,
  input logic              rst,
  alu_dot_sequencer_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] MUL   = 3'd2;
  localparam logic [2:0] ADD   = 3'd3;
  localparam logic [2:0] WB    = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  logic [2:0]    state_q, state_d;
  logic [AW-1:0] len_q, len_d, stride_q, stride_d, a_addr_q, a_addr_d, b_addr_q, b_addr_d, k_q, k_d;
  logic [DW-1:0] acc_q, acc_d, result_q, result_d;
  logic          last;
  assign last = k_q == len_q - AW'(1);
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    stride_d = stride_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    k_d      = k_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (bus.start_i) begin
        len_d    = bus.len_i;
        stride_d = bus.b_stride_i;
        a_addr_d = bus.a_base_i;
        b_addr_d = bus.b_base_i;
        acc_d    = '0;
        k_d      = '0;
        state_d  = bus.len_i == '0 ? DONE : FETCH;
      end
      FETCH: state_d = MUL;
      MUL:   state_d = ADD;
      ADD:   state_d = WB;
      WB: begin
        acc_d = bus.alu_c_i;
        if (last) state_d = DONE;
        else begin
          k_d      = k_q + AW'(1);
          a_addr_d = a_addr_q + AW'(1);
          b_addr_d = b_addr_q + stride_q;
          state_d  = FETCH;
        end
      end
      DONE: begin
        result_d = acc_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      stride_q <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      stride_q <= stride_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end
  // result is exposed straight from acc during DONE so it is valid in the done cycle itself
  assign bus.a_addr_o     = a_addr_q;
  assign bus.b_addr_o     = b_addr_q;
  assign bus.mem_rd_o     = state_q == FETCH;
  assign bus.alu_opcode_o = state_q == MUL ? 2'd3 : state_q == ADD ? 2'd1 : 2'd0;
  assign bus.alu_a_o      = state_q == MUL ? bus.a_data_i : state_q == ADD ? acc_q : '0;
  assign bus.alu_b_o      = state_q == MUL ? bus.b_data_i : state_q == ADD ? bus.alu_c_i : '0;
  assign bus.busy_o       = state_q != IDLE && state_q != DONE;
  assign bus.done_o       = state_q == DONE;
  assign bus.result_o     = state_q == DONE ? acc_q : result_q;
endmodule

// File: tb/tb_alu_dot_sequencer.sv
// tb_alu_dot_sequencer: directed jobs against a schedule/sum model with memory and ALU stand-ins
module tb_alu_dot_sequencer;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  alu_dot_sequencer_if bus();
  alu_dot_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  logic [15:0] A [256];
  logic [15:0] B [256];
  int checks = 0, errors = 0;
  logic [7:0] m_len, m_ab, m_bb, m_st;
  int job_id = 0, job_seen = 0, abort_id = 0, ab_seen = 0;
  int active = 0, cyc = 0, done_cyc = -1, done_cnt = 0, rd_cnt = 0;
  logic [15:0] hold = 0, res_seen = 0;
  logic [7:0] fb [4];
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", n, act, exp, $time);
    end
  endfunction
  function automatic logic [7:0] a_at(int k); return 8'(int'(m_ab) + k); endfunction
  function automatic logic [7:0] b_at(int k); return 8'(int'(m_bb) + k * int'(m_st)); endfunction
  function automatic logic [15:0] prod(int k); return 16'(A[a_at(k)] * B[b_at(k)]); endfunction
  function automatic logic [15:0] psum(int n);
    logic [15:0] s = 0;
    for (int k = 0; k < n; k++) s = s + prod(k);
    return s;
  endfunction
  // operand memories with one-cycle read latency, and a registered ALU
  always @(posedge clk) begin
    if (bus.mem_rd_o) begin
      bus.a_data_i <= A[bus.a_addr_o];
      bus.b_data_i <= B[bus.b_addr_o];
    end
    case (bus.alu_opcode_o)
      2'd0: bus.alu_c_i <= bus.alu_a_o;
      2'd1: bus.alu_c_i <= bus.alu_a_o + bus.alu_b_o;
      2'd2: bus.alu_c_i <= bus.alu_a_o - bus.alu_b_o;
      default: bus.alu_c_i <= 16'(bus.alu_a_o * bus.alu_b_o);
    endcase
  end
  always @(negedge clk) begin
    int ph, t, last;
    logic run;
    if (abort_id != ab_seen) begin ab_seen = abort_id; active = 0; hold = 0; end
    if (job_id != job_seen) begin
      job_seen = job_id; active = 1; cyc = 0; done_cyc = -1; res_seen = 16'hdead;
    end
    if (active != 0) begin
      cyc++;
      ph = (cyc - 1) % 4;
      t = (cyc - 1) / 4;
      last = 4 * int'(m_len) + 1;
      run = cyc < last;
      chk("busy", bus.busy_o, run);
      chk("done", bus.done_o, cyc == last);
      chk("mem_rd", bus.mem_rd_o, run && ph == 0);
      chk("opcode", bus.alu_opcode_o, !run ? 0 : ph == 1 ? 3 : ph == 2 ? 1 : 0);
      chk("alu_a", bus.alu_a_o, run && ph == 1 ? A[a_at(t)] : run && ph == 2 ? psum(t) : 16'd0);
      chk("alu_b", bus.alu_b_o, run && ph == 1 ? B[b_at(t)] : run && ph == 2 ? prod(t) : 16'd0);
      if (run && ph == 0) begin
        chk("a_addr", bus.a_addr_o, a_at(t));
        chk("b_addr", bus.b_addr_o, b_at(t));
        if (t < 4) fb[t] = bus.b_addr_o;
      end
      if (cyc >= last) begin
        chk("result", bus.result_o, psum(int'(m_len)));
        hold = psum(int'(m_len));
        done_cyc = cyc;
        res_seen = bus.result_o;
        active = 0;
      end
    end else begin
      chk("idle_busy", bus.busy_o, 0);
      chk("idle_done", bus.done_o, 0);
      chk("idle_mem_rd", bus.mem_rd_o, 0);
      chk("idle_opcode", bus.alu_opcode_o, 0);
      chk("idle_alu_a", bus.alu_a_o, 0);
      chk("idle_alu_b", bus.alu_b_o, 0);
      chk("idle_result", bus.result_o, hold);
    end
    if (bus.done_o) done_cnt++;
    if (bus.mem_rd_o) rd_cnt++;
  end
  task automatic run_job(input logic [7:0] l, ab, bb, st, input int p1, p2, rc);
    @(negedge clk);
    bus.start_i = 1; bus.len_i = l; bus.a_base_i = ab; bus.b_base_i = bb; bus.b_stride_i = st;
    @(posedge clk);
    #1;
    bus.start_i = 0; m_len = l; m_ab = ab; m_bb = bb; m_st = st;
    job_id++;
    for (int i = 1; i <= 4 * int'(l) + 3; i++) begin
      @(negedge clk);
      bus.len_i = 8'($urandom_range(1, 255)); bus.a_base_i = 8'($urandom);
      bus.b_base_i = 8'($urandom); bus.b_stride_i = 8'($urandom);
      bus.start_i = i == p1 || i == p2;
      if (i == rc) begin
        #1 rst = 1;
        abort_id++;
        @(negedge clk);
        chk("rst_a_addr", bus.a_addr_o, 0);
        chk("rst_b_addr", bus.b_addr_o, 0);
        #1 rst = 0;
        break;
      end
    end
    @(negedge clk);
    bus.start_i = 0;
  endtask
  initial begin
    int d0, r0;
    for (int i = 0; i < 256; i++) begin A[i] = 0; B[i] = 0; end
    bus.start_i = 0; bus.len_i = 0; bus.a_base_i = 0; bus.b_base_i = 0; bus.b_stride_i = 0;
    bus.a_data_i = 0; bus.b_data_i = 0; bus.alu_c_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_a_addr", bus.a_addr_o, 0);
    chk("reset_result", bus.result_o, 0);
    chk("reset_busy", bus.busy_o, 0);
    #1 rst = 0;
    A[0] = 1; A[1] = 2; A[2] = 3; B[16] = 4; B[17] = 5; B[18] = 6;
    run_job(3, 0, 16, 1, 0, 0, 0);
    chk("t1_done_cyc", done_cyc, 13);
    chk("t1_result", res_seen, 32);
    r0 = rd_cnt;
    run_job(0, 5, 5, 3, 0, 0, 0);
    chk("t2_done_cyc", done_cyc, 1);
    chk("t2_result", res_seen, 0);
    chk("t2_no_mem_rd", rd_cnt, r0);
    A[40] = 7; A[41] = 9; B[250] = 11; B[2] = 13;
    run_job(2, 40, 250, 8, 0, 0, 0);
    chk("t3_b_addr0", fb[0], 250);
    chk("t3_b_addr1", fb[1], 2);
    chk("t3_result", res_seen, 194);
    A[60] = 16'h0100; A[61] = 16'h0100; B[70] = 16'h0100; B[71] = 16'h0001;
    run_job(2, 60, 70, 1, 0, 0, 0);
    chk("t4_result", res_seen, 16'h0100);
    d0 = done_cnt;
    run_job(3, 0, 16, 1, 5, 13, 0);
    chk("t5_one_done", done_cnt - d0, 1);
    chk("t5_done_cyc", done_cyc, 13);
    chk("t5_result", res_seen, 32);
    d0 = done_cnt;
    run_job(3, 0, 16, 1, 0, 0, 7);
    chk("t6_no_done", done_cnt - d0, 0);
    run_job(2, 40, 250, 8, 0, 0, 0);
    chk("t6_after_done_cyc", done_cyc, 9);
    chk("t6_after_result", res_seen, 194);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
